// File: rtl/muldiv_execute_stage_if.sv
// Handshake/data bundle for the M-extension execute stage.
// master: upstream/downstream side (drives op fields, prev_done, next_stall)
// slave : the stage (drives stall_prev, done_next, result_out, sideband_out, busy_out)
interface muldiv_execute_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int SIDEBAND_WIDTH = 64
);
    logic                      prev_done;
    logic                      stall_prev;
    logic                      next_stall;
    logic                      done_next;
    logic                      muldiv_in;
    logic [2:0]                funct_3_in;
    logic [DATA_WIDTH-1:0]     lhs_in;
    logic [DATA_WIDTH-1:0]     rhs_in;
    logic [DATA_WIDTH-1:0]     bypass_result_in;
    logic [SIDEBAND_WIDTH-1:0] sideband_in;
    logic [DATA_WIDTH-1:0]     result_out;
    logic [SIDEBAND_WIDTH-1:0] sideband_out;
    logic                      busy_out;

    modport master (
        output prev_done, next_stall, muldiv_in, funct_3_in, lhs_in, rhs_in,
               bypass_result_in, sideband_in,
        input  stall_prev, done_next, result_out, sideband_out, busy_out
    );

    modport slave (
        input  prev_done, next_stall, muldiv_in, funct_3_in, lhs_in, rhs_in,
               bypass_result_in, sideband_in,
        output stall_prev, done_next, result_out, sideband_out, busy_out
    );
endinterface

// File: rtl/muldiv_execute_stage.sv
// Multi-cycle execute stage adding RV32M mul/div/rem to the execute path.
// Non-M ops pass through in one cycle; M ops use an iterative shift-add
// multiplier (or a single-cycle multiply when MUL_FAST=1) and a restoring
// divider, back-pressuring upstream while busy.
// Ports: clk, rst (sync, active-high), bus (slave modport: prev_done/stall_prev
// upstream handshake, done_next/next_stall downstream handshake, op fields,
// result_out, sideband_out, busy_out).
module muldiv_execute_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int SIDEBAND_WIDTH = 64,
    parameter int MUL_FAST       = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    muldiv_execute_stage_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {EMPTY, MUL, DIV, DONE} state_t;

    state_t                    state_q;
    logic [CW-1:0]             cnt_q;
    logic [W-1:0]              acc_q;    // mul: running high half; div: partial remainder
    logic [W-1:0]              lo_q;     // mul: multiplier / low product; div: dividend / quotient
    logic [W-1:0]              opnd_q;   // mul: multiplicand magnitude; div: divisor magnitude
    logic [W-1:0]              result_q;
    logic [SIDEBAND_WIDTH-1:0] sb_q;
    logic                      neg_q;    // negate the final magnitude
    logic                      hi_q;     // mul: take high half
    logic                      rem_q;    // div: take remainder

    logic done, tnext, tprev, stall;

    assign done  = !rst && state_q == DONE;
    assign tnext = done && !bus.next_stall;
    assign stall = rst || (state_q != EMPTY && !(state_q == DONE && tnext));
    assign tprev = bus.prev_done && !stall;

    assign bus.done_next    = done;
    assign bus.stall_prev   = stall;
    assign bus.result_out   = result_q;
    assign bus.sideband_out = sb_q;
    assign bus.busy_out     = state_q == MUL || state_q == DIV;

    // Accept-time decode: signedness, magnitudes and the no-iteration div cases.
    logic [2:0]   f3;
    logic         sgn_a, sgn_b, div0, ovf;
    logic [W-1:0] mag_a, mag_b, fast_res;

    always_comb begin
        f3    = bus.funct_3_in;
        sgn_a = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6) && bus.lhs_in[W-1];
        sgn_b = (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6) && bus.rhs_in[W-1];
        mag_a = sgn_a ? -bus.lhs_in : bus.lhs_in;
        mag_b = sgn_b ? -bus.rhs_in : bus.rhs_in;
        div0  = bus.rhs_in == '0;
        ovf   = !f3[0] && bus.lhs_in == {1'b1, {(W-1){1'b0}}} && (&bus.rhs_in);
        if (div0) fast_res = f3[1] ? bus.lhs_in : '1;
        else      fast_res = f3[1] ? '0 : bus.lhs_in;
    end

    // One iteration step of each unit plus sign-corrected final results.
    logic [W:0]     mul_sum, div_r;
    logic           div_ge;
    logic [W-1:0]   div_sub, acc_n, lo_n, div_pick, mul_res, div_res;
    logic [2*W-1:0] prod, prod_s;

    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_r   = {acc_q, lo_q[W-1]};
        div_ge  = div_r >= {1'b0, opnd_q};
        div_sub = W'(div_r - {1'b0, opnd_q});
        if (state_q == DIV) begin
            acc_n = div_ge ? div_sub : div_r[W-1:0];
            lo_n  = {lo_q[W-2:0], div_ge};
        end else begin
            acc_n = mul_sum[W:1];
            lo_n  = {mul_sum[0], lo_q[W-1:1]};
        end
        if (MUL_FAST != 0) prod = {{W{1'b0}}, opnd_q} * {{W{1'b0}}, lo_q};
        else               prod = {acc_n, lo_n};
        prod_s   = neg_q ? -prod : prod;
        mul_res  = hi_q ? prod_s[2*W-1:W] : prod_s[W-1:0];
        div_pick = rem_q ? acc_n : lo_n;
        div_res  = neg_q ? -div_pick : div_pick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            sb_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
            rem_q    <= 1'b0;
        end else begin
            case (state_q)
                MUL, DIV: begin
                    acc_q <= acc_n;
                    lo_q  <= lo_n;
                    if ((state_q == MUL && MUL_FAST != 0) || cnt_q == CNT_LAST) begin
                        state_q  <= DONE;
                        cnt_q    <= '0;
                        result_q <= (state_q == MUL) ? mul_res : div_res;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    if (tnext) state_q <= EMPTY;
                default: ;
            endcase
            // Accept overrides the drain transition for back-to-back ops.
            if (tprev) begin
                sb_q  <= bus.sideband_in;
                cnt_q <= '0;
                acc_q <= '0;
                hi_q  <= f3[1:0] != 2'd0;
                rem_q <= f3[1];
                if (!bus.muldiv_in) begin
                    state_q  <= DONE;
                    result_q <= bus.bypass_result_in;
                end else if (!f3[2]) begin
                    state_q <= MUL;
                    opnd_q  <= mag_a;
                    lo_q    <= mag_b;
                    neg_q   <= sgn_a ^ sgn_b;
                end else if (div0 || ovf) begin
                    state_q  <= DONE;
                    result_q <= fast_res;
                end else begin
                    state_q <= DIV;
                    opnd_q  <= mag_b;
                    lo_q    <= mag_a;
                    neg_q   <= f3[1] ? sgn_a : (sgn_a ^ sgn_b);
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_execute_stage.sv
module tb_muldiv_execute_stage;
    localparam int W  = 32;
    localparam int SB = 64;

    logic clk, rst;
    int   checks = 0, failures = 0;

    muldiv_execute_stage_if #(.DATA_WIDTH(W), .SIDEBAND_WIDTH(SB)) bus ();
    muldiv_execute_stage #(.DATA_WIDTH(W), .SIDEBAND_WIDTH(SB), .MUL_FAST(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics via 64-bit arithmetic.
    function automatic logic [31:0] ref_res(bit md, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                                            logic [31:0] byp);
        longint    sa  = longint'($signed(a));
        longint    sb  = longint'($signed(b));
        longint    ua  = longint'({32'd0, a});
        longint    ub  = longint'({32'd0, b});
        bit        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        logic [63:0] p;
        if (!md) return byp;
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(bit md, logic [2:0] f, logic [31:0] a, logic [31:0] b);
        if (!md) return 1;
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return W + 1;
    endfunction

    task automatic drive(input bit md, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] byp, input logic [63:0] sb);
        bus.prev_done        = 1'b1;
        bus.muldiv_in        = md;
        bus.funct_3_in       = f;
        bus.lhs_in           = a;
        bus.rhs_in           = b;
        bus.bypass_result_in = byp;
        bus.sideband_in      = sb;
    endtask

    task automatic scramble();
        bus.prev_done        = 1'b0;
        bus.muldiv_in        = 1'($urandom);
        bus.funct_3_in       = 3'($urandom);
        bus.lhs_in           = $urandom;
        bus.rhs_in           = $urandom;
        bus.bypass_result_in = $urandom;
        bus.sideband_in      = {$urandom, $urandom};
    endtask

    // Wait (bounded) for the op to be accepted; returns after the accept edge.
    task automatic wait_accept(input string tag);
        int g = 0;
        #1;
        while (bus.stall_prev && g < 200) begin
            @(negedge clk); #1; g++;
        end
        if (g >= 200) chk({tag, "_accept_timeout"}, 64'(g), 64'd0);
        @(posedge clk); #1;
        scramble();
    endtask

    task automatic send_op(input string tag, input bit md, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] byp, input logic [63:0] sb,
                           input int hold);
        logic [31:0] er  = ref_res(md, f, a, b, byp);
        int          el  = ref_lat(md, f, a, b);
        int          lat = 0, busy = 0, nostall = 0;
        @(negedge clk);
        drive(md, f, a, b, byp, sb);
        wait_accept(tag);
        do begin
            @(negedge clk); lat++;
            if (!bus.done_next) begin
                busy    += int'(bus.busy_out);
                nostall += int'(!bus.stall_prev);
            end
        end while (!bus.done_next && lat < 200);
        chk({tag, "_lat"},  64'(lat), 64'(el));
        chk({tag, "_res"},  64'(bus.result_out), 64'(er));
        chk({tag, "_sb"},   bus.sideband_out, sb);
        chk({tag, "_busy"}, 64'(busy), 64'(el - 1));
        chk({tag, "_stall_busy"}, 64'(nostall), 64'd0);
        if (hold > 0) begin
            bus.next_stall = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk({tag, "_hold_res"},   64'(bus.result_out), 64'(er));
                chk({tag, "_hold_done"},  64'(bus.done_next), 64'd1);
                chk({tag, "_hold_stall"}, 64'(bus.stall_prev), 64'd1);
            end
            bus.next_stall = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, "_drain"}, 64'(bus.done_next), 64'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.next_stall = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        chk("rst_done",   64'(bus.done_next), 64'd0);
        chk("rst_busy",   64'(bus.busy_out), 64'd0);
        chk("rst_res",    64'(bus.result_out), 64'd0);
        chk("rst_sb",     bus.sideband_out, 64'd0);
        chk("rst_stall",  64'(bus.stall_prev), 64'd1);
        rst = 1'b0;

        // Back-to-back bypass, one result per cycle.
        begin
            logic [31:0] byp [4] = '{32'h1, 32'h2, 32'h3, 32'h1234};
            for (int i = 0; i <= 4; i++) begin
                @(negedge clk);
                if (i > 0) begin
                    chk("b2b_done", 64'(bus.done_next), 64'd1);
                    chk("b2b_res",  64'(bus.result_out), 64'(byp[i-1]));
                    chk("b2b_sb",   bus.sideband_out, 64'hA0 + 64'(i - 1));
                end
                if (i < 4) begin
                    drive(1'b0, 3'($urandom), $urandom, $urandom, byp[i], 64'hA0 + 64'(i));
                    #1 chk("b2b_acc", 64'(bus.stall_prev), 64'd0);
                end else begin
                    scramble();
                end
            end
            @(posedge clk); #1;
            chk("b2b_drain", 64'(bus.done_next), 64'd0);
        end

        // Directed multiply / divide / fast paths.
        send_op("mul",    1, 3'd0, 32'd7, 32'hFFFF_FFFD, 0, 64'h11, 0);
        send_op("mulh",   1, 3'd1, 32'd7, 32'hFFFF_FFFD, 0, 64'h12, 0);
        send_op("mulhu",  1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'h13, 1);
        send_op("mulhsu", 1, 3'd2, 32'hFFFF_FFFF, 32'd2, 0, 64'h14, 0);
        send_op("div",    1, 3'd4, 32'hFFFF_FFF9, 32'd2, 0, 64'h21, 0);
        send_op("rem",    1, 3'd6, 32'hFFFF_FFF9, 32'd2, 0, 64'h22, 0);
        send_op("divu",   1, 3'd5, 32'd100, 32'd7, 0, 64'h23, 0);
        send_op("remu",   1, 3'd7, 32'd100, 32'd7, 0, 64'h24, 2);
        send_op("divu0",  1, 3'd5, 32'd5, 32'd0, 0, 64'h31, 0);
        send_op("rem0",   1, 3'd6, 32'd5, 32'd0, 0, 64'h32, 0);
        send_op("divovf", 1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 64'h33, 0);
        send_op("removf", 1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 64'h34, 0);

        // Back-pressure at DONE, then release with a same-edge accept.
        begin
            int lat = 0;
            @(negedge clk);
            drive(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, 0, 64'h51);
            wait_accept("bp");
            bus.next_stall = 1'b1;
            do begin @(negedge clk); lat++; end while (!bus.done_next && lat < 200);
            chk("bp_lat", 64'(lat), 64'(W + 1));
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(negedge clk);
                chk("bp_res",   64'(bus.result_out), 64'hFFFF_FFEB);
                chk("bp_sb",    bus.sideband_out, 64'h51);
                chk("bp_stall", 64'(bus.stall_prev), 64'd1);
            end
            @(negedge clk);
            bus.next_stall = 1'b0;
            drive(1'b0, 3'd0, 0, 0, 32'hAA, 64'h52);
            #1 chk("bp_rel_acc", 64'(bus.stall_prev), 64'd0);
            @(posedge clk); #1;
            scramble();
            @(negedge clk);
            chk("bp_new_done", 64'(bus.done_next), 64'd1);
            chk("bp_new_res",  64'(bus.result_out), 64'hAA);
            chk("bp_new_sb",   bus.sideband_out, 64'h52);
            @(posedge clk); #1;
        end

        // Reset mid-multiply.
        @(negedge clk);
        drive(1'b1, 3'd0, 32'd9, 32'd11, 0, 64'h61);
        wait_accept("rmid");
        repeat (10) @(negedge clk);
        chk("rmid_busy_pre", 64'(bus.busy_out), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rmid_done",  64'(bus.done_next), 64'd0);
        chk("rmid_busy",  64'(bus.busy_out), 64'd0);
        chk("rmid_res",   64'(bus.result_out), 64'd0);
        chk("rmid_stall", 64'(bus.stall_prev), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        send_op("post_rst_mul", 1, 3'd0, 32'd3, 32'd5, 0, 64'h62, 0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            send_op("rnd", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick_val(), pick_val(),
                    $urandom, {$urandom, $urandom}, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
